// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame FSM states and the CPOL/CPHA decode of a mode
// number. The master and the slave both use this decode so the two sides
// always agree on the meaning of a mode number.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT_NEXT,
        CS_GAP
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Modes 2/3 idle SCLK high; modes 1/3 sample on the trailing edge.
    function automatic spi_mode_t spi_mode_decode(input int mode);
        spi_mode_t m;
        m.cpol = (mode == 2) || (mode == 3);
        m.cpha = (mode == 1) || (mode == 3);
        return m;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Byte-level handshake between the user logic and the SPI master.
// The master modport is the SPI master's view; slave is the user side.
interface spi_master_if #(
    parameter int MAX_BYTES_PER_CS = 4
);
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

    logic [CW-1:0] i_TX_Count;
    logic [7:0]    i_TX_Byte;
    logic          i_TX_DV;
    logic          o_TX_Ready;
    logic          o_RX_DV;
    logic [7:0]    o_RX_Byte;
    logic [CW-1:0] o_RX_Count;

    modport master (
        input  i_TX_Count, i_TX_Byte, i_TX_DV,
        output o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count
    );

    modport slave (
        output i_TX_Count, i_TX_Byte, i_TX_DV,
        input  o_TX_Ready, o_RX_DV, o_RX_Byte, o_RX_Count
    );

endinterface

// File: rtl/spi_master_byte.sv
// Single-byte SPI engine: divides i_Clk into SCLK, shifts one byte out on
// MOSI (MSb first) and one byte in from MISO over 16 SCLK edges, then pulses
// o_Done for one cycle with the received byte stable on o_RX_Byte.
module spi_master_byte
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Start,
    input  logic [7:0] i_Byte,
    input  logic       i_Clr_MOSI,
    input  logic       i_MISO,
    output logic       o_Done,
    output logic [7:0] o_RX_Byte,
    output logic       o_SPI_Clk,
    output logic       o_SPI_MOSI
);
    localparam spi_mode_t MODE = spi_mode_decode(SPI_MODE);
    localparam int        HW   = $clog2(CLKS_PER_HALF_BIT);

    logic          busy;
    logic [HW-1:0] half_cnt;
    logic [4:0]    edge_cnt;   // SCLK edges already produced in this byte
    logic [7:0]    tx_sh;
    logic [7:0]    rx_sh;
    logic          tick;
    logic          leading;
    logic          last_edge;
    logic          sample;
    logic          drive;

    // Decode the edge about to be produced: edge number is edge_cnt+1,
    // odd edges lead. CPHA=0 never shifts MOSI on edge 16 so bit0 is held.
    always_comb begin
        tick      = busy && (half_cnt == HW'(CLKS_PER_HALF_BIT - 1));
        leading   = ~edge_cnt[0];
        last_edge = (edge_cnt == 5'd15);
        sample    = tick && (leading ^ MODE.cpha);
        drive     = tick && (MODE.cpha ? leading : (!leading && !last_edge));
    end

    // Half-bit timer, SCLK toggle and the TX/RX shift registers.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            busy       <= 1'b0;
            half_cnt   <= '0;
            edge_cnt   <= '0;
            tx_sh      <= '0;
            rx_sh      <= '0;
            o_Done     <= 1'b0;
            o_SPI_Clk  <= MODE.cpol;
            o_SPI_MOSI <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            if (i_Start) begin
                busy     <= 1'b1;
                half_cnt <= '0;
                edge_cnt <= '0;
                if (!MODE.cpha) begin
                    // bit7 must be on the wire before the first leading edge
                    o_SPI_MOSI <= i_Byte[7];
                    tx_sh      <= {i_Byte[6:0], 1'b0};
                end else begin
                    tx_sh <= i_Byte;
                end
            end else if (busy) begin
                if (tick) begin
                    half_cnt  <= '0;
                    o_SPI_Clk <= ~o_SPI_Clk;
                    edge_cnt  <= edge_cnt + 5'd1;
                    if (sample) rx_sh <= {rx_sh[6:0], i_MISO};
                    if (drive) begin
                        o_SPI_MOSI <= tx_sh[7];
                        tx_sh      <= {tx_sh[6:0], 1'b0};
                    end
                    if (last_edge) begin
                        busy   <= 1'b0;
                        o_Done <= 1'b1;
                    end
                end else begin
                    half_cnt <= half_cnt + 1'b1;
                end
            end
            if (i_Clr_MOSI) o_SPI_MOSI <= 1'b0;
        end
    end

    assign o_RX_Byte = rx_sh;

endmodule

// File: rtl/spi_master.sv
// SPI master top: frame FSM, byte/RX counters and CS_n around the byte engine.
// A frame of up to MAX_BYTES_PER_CS bytes keeps CS_n low; after the last byte
// CS_n stays high for at least CS_INACTIVE_CLKS cycles before the next frame.
module spi_master
    import spi_pkg::*;
#(
    parameter int SPI_MODE          = 0,
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int MAX_BYTES_PER_CS  = 4,
    parameter int CS_INACTIVE_CLKS  = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    spi_master_if.master     bus,
    output logic             o_SPI_Clk,
    input  logic             i_SPI_MISO,
    output logic             o_SPI_MOSI,
    output logic             o_SPI_CS_n
);
    localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
    localparam int GW = $clog2(CS_INACTIVE_CLKS + 1);

    spi_state_e    state, state_d;
    logic [CW-1:0] frame_len;
    logic [CW-1:0] tx_cnt;     // bytes started in this frame
    logic [CW-1:0] rx_cnt;
    logic [GW-1:0] gap_cnt;
    logic          tx_ready, tx_ready_d;
    logic          cs_n, cs_n_d;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          accept;
    logic          frame_end;
    logic          done;
    logic [7:0]    eng_rx;

    // Only accept while ready; ready is registered, so a DV during a byte is
    // simply dropped.
    assign accept = bus.i_TX_DV && tx_ready;

    // Frame FSM state register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= IDLE;
        else       state <= state_d;
    end

    // Next state plus the next values of the registered ready and CS_n.
    always_comb begin
        state_d    = state;
        tx_ready_d = 1'b0;
        cs_n_d     = cs_n;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                tx_ready_d = 1'b1;
                cs_n_d     = 1'b1;
                if (accept) begin
                    state_d    = XFER;
                    tx_ready_d = 1'b0;
                    cs_n_d     = 1'b0;
                end
            end
            XFER: begin
                if (done) begin
                    if (tx_cnt < frame_len) begin
                        state_d    = WAIT_NEXT;
                        tx_ready_d = 1'b1;
                    end else begin
                        state_d   = CS_GAP;
                        cs_n_d    = 1'b1;
                        frame_end = 1'b1;
                    end
                end
            end
            WAIT_NEXT: begin
                tx_ready_d = 1'b1;
                if (accept) begin
                    state_d    = XFER;
                    tx_ready_d = 1'b0;
                end
            end
            CS_GAP: begin
                // ready rises together with the return to IDLE so a request
                // on the first ready cycle gives CS_INACTIVE_CLKS+1 high cycles
                if (gap_cnt == GW'(CS_INACTIVE_CLKS - 1)) begin
                    state_d    = IDLE;
                    tx_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers, frame/RX counters and the CS gap timer.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            tx_ready  <= 1'b0;
            cs_n      <= 1'b1;
            rx_dv     <= 1'b0;
            rx_byte   <= '0;
            frame_len <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            tx_ready <= tx_ready_d;
            cs_n     <= cs_n_d;
            rx_dv    <= done;
            if (done) rx_byte <= eng_rx;
            if (state == CS_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                 gap_cnt <= '0;
            if (accept && state == IDLE) begin
                // a zero count still sends the byte that was just handed over
                frame_len <= (bus.i_TX_Count == '0) ? CW'(1) : bus.i_TX_Count;
                tx_cnt    <= CW'(1);
                rx_cnt    <= '0;
            end else begin
                if (accept) tx_cnt <= tx_cnt + 1'b1;
                if (rx_dv)  rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    spi_master_byte #(
        .SPI_MODE          (SPI_MODE),
        .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
    ) u_byte (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .i_Start    (accept),
        .i_Byte     (bus.i_TX_Byte),
        .i_Clr_MOSI (frame_end),
        .i_MISO     (i_SPI_MISO),
        .o_Done     (done),
        .o_RX_Byte  (eng_rx),
        .o_SPI_Clk  (o_SPI_Clk),
        .o_SPI_MOSI (o_SPI_MOSI)
    );

    assign bus.o_TX_Ready = tx_ready;
    assign bus.o_RX_DV    = rx_dv;
    assign bus.o_RX_Byte  = rx_byte;
    assign bus.o_RX_Count = rx_cnt;
    assign o_SPI_CS_n     = cs_n;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one instance per SPI mode sharing clock and
// reset. Mode 0 loops MOSI back to MISO; modes 1..3 talk to a small slave
// model that returns 0xC3 and captures MOSI on its own sampling edges.
module tb_spi_master;

    logic            clk;
    logic            rst;
    logic [3:0]      tx_dv;
    logic [3:0][7:0] tx_byte;
    logic [3:0][2:0] tx_count;
    logic [3:0]      tx_ready;
    logic [3:0]      rx_dv;
    logic [3:0][7:0] rx_byte;
    logic [3:0][2:0] rx_count;
    logic [3:0]      sclk;
    logic [3:0]      mosi;
    logic [3:0]      miso;
    logic [3:0]      cs_n;
    logic [3:0][4:0] edges;
    logic [3:0][7:0] srx;

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave reply bit for a given count of SCLK edges since CS_n fell.
    function automatic logic slave_bit(input int e, input bit cpha);
        logic [7:0] pat;
        int idx;
        pat = 8'hC3;
        idx = cpha ? ((e + 1) / 2 - 1) : (e / 2);
        if (idx < 0) idx = 0;
        if (idx > 7) idx = 7;
        return pat[7 - idx];
    endfunction

    for (genvar m = 0; m < 4; m++) begin : g_mode
        localparam bit CPHA = (m == 1) || (m == 3);

        spi_master_if #(.MAX_BYTES_PER_CS(4)) bus ();

        assign bus.i_TX_Count = tx_count[m];
        assign bus.i_TX_Byte  = tx_byte[m];
        assign bus.i_TX_DV    = tx_dv[m];
        assign tx_ready[m]    = bus.o_TX_Ready;
        assign rx_dv[m]       = bus.o_RX_DV;
        assign rx_byte[m]     = bus.o_RX_Byte;
        assign rx_count[m]    = bus.o_RX_Count;

        spi_master #(
            .SPI_MODE          (m),
            .CLKS_PER_HALF_BIT (2),
            .MAX_BYTES_PER_CS  (4),
            .CS_INACTIVE_CLKS  (4)
        ) dut (
            .i_Clk      (clk),
            .i_Rst      (rst),
            .bus        (bus),
            .o_SPI_Clk  (sclk[m]),
            .i_SPI_MISO (miso[m]),
            .o_SPI_MOSI (mosi[m]),
            .o_SPI_CS_n (cs_n[m])
        );

        int         e;
        logic [7:0] s_rx;
        logic       sclk_q;
        logic       cs_q;

        // Slave: count SCLK edges inside CS_n low, capture MOSI on its edges.
        always @(sclk[m] or cs_n[m]) begin
            if (cs_n[m] === 1'b0 && cs_q !== 1'b0) begin
                e    = 0;
                s_rx = 8'h00;
            end else if (cs_n[m] === 1'b0 && sclk[m] !== sclk_q) begin
                e = e + 1;
                if (((e % 2) == 1) != CPHA) s_rx = {s_rx[6:0], mosi[m]};
            end
            cs_q   = cs_n[m];
            sclk_q = sclk[m];
        end

        assign miso[m]  = (m == 0) ? mosi[m] : slave_bit(e, CPHA);
        assign edges[m] = e[4:0];
        assign srx[m]   = s_rx;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int bad;

    initial begin
        rst      = 1'b0;
        tx_dv    = '0;
        tx_byte  = '0;
        tx_count = '0;
        #1 rst = 1'b1;
        #1;
        // reset state
        for (int m = 0; m < 4; m++) begin
            check($sformatf("rst cs m%0d", m),    32'(cs_n[m]),     32'd1);
            check($sformatf("rst sclk m%0d", m),  32'(sclk[m]),     32'((m == 2) || (m == 3)));
            check($sformatf("rst mosi m%0d", m),  32'(mosi[m]),     32'd0);
            check($sformatf("rst ready m%0d", m), 32'(tx_ready[m]), 32'd0);
        end
        check("rst rxdv",  32'(rx_dv[0]),    32'd0);
        check("rst rxb",   32'(rx_byte[0]),  32'd0);
        check("rst rxcnt", 32'(rx_count[0]), 32'd0);
        tick(2);
        rst = 1'b0;
        #1;
        check("ready before edge", 32'(tx_ready), 32'h0);
        tick(1);
        check("ready after release", 32'(tx_ready), 32'hF);

        // mode 0 loopback, single byte 0xA5
        tx_byte[0] = 8'hA5; tx_count[0] = 3'd1; tx_dv[0] = 1'b1;
        tick(1);
        tx_dv[0] = 1'b0;
        check("t1 cs low N+1",  32'(cs_n[0]),     32'd0);
        check("t1 mosi bit7",   32'(mosi[0]),     32'd1);
        check("t1 ready low",   32'(tx_ready[0]), 32'd0);
        tick(32);
        check("t1 rxdv N+33",   32'(rx_dv[0]),    32'd0);
        check("t1 cs N+33",     32'(cs_n[0]),     32'd0);
        tick(1);
        check("t1 rxdv N+34",   32'(rx_dv[0]),    32'd1);
        check("t1 rxbyte",      32'(rx_byte[0]),  32'hA5);
        check("t1 rxcount",     32'(rx_count[0]), 32'd0);
        check("t1 cs high",     32'(cs_n[0]),     32'd1);
        check("t1 sclk idle",   32'(sclk[0]),     32'd0);
        check("t1 edges",       32'(edges[0]),    32'd16);
        check("t1 slave saw",   32'(srx[0]),      32'hA5);
        tick(1);
        check("t1 rxdv pulse",  32'(rx_dv[0]),    32'd0);
        check("t1 rxcount inc", 32'(rx_count[0]), 32'd1);

        // modes 1..3 against the 0xC3 slave
        for (int m = 1; m < 4; m++) begin
            tx_byte[m] = 8'h3C; tx_count[m] = 3'd1; tx_dv[m] = 1'b1;
        end
        tick(1);
        tx_dv = '0;
        tick(33);
        for (int m = 1; m < 4; m++) begin
            check($sformatf("t2 rxdv m%0d", m),  32'(rx_dv[m]),   32'd1);
            check($sformatf("t2 rxb m%0d", m),   32'(rx_byte[m]), 32'hC3);
            check($sformatf("t2 mosi m%0d", m),  32'(srx[m]),     32'h3C);
            check($sformatf("t2 sclk m%0d", m),  32'(sclk[m]),    32'(m >= 2));
            check($sformatf("t2 cs m%0d", m),    32'(cs_n[m]),    32'd1);
            check($sformatf("t2 edges m%0d", m), 32'(edges[m]),   32'd16);
        end

        // mode 0, 3-byte frame with a 10-cycle pause before byte 2
        check("t3 ready", 32'(tx_ready[0]), 32'd1);
        tx_byte[0] = 8'h01; tx_count[0] = 3'd3; tx_dv[0] = 1'b1;
        tick(1);
        tx_dv[0] = 1'b0;
        tick(33);
        check("t3 b0 rxdv",  32'(rx_dv[0]),    32'd1);
        check("t3 b0 rxb",   32'(rx_byte[0]),  32'h01);
        check("t3 b0 cnt",   32'(rx_count[0]), 32'd0);
        check("t3 b0 cs",    32'(cs_n[0]),     32'd0);
        check("t3 b0 ready", 32'(tx_ready[0]), 32'd1);
        bad = 0;
        repeat (10) begin
            tick(1);
            if (cs_n[0] !== 1'b0 || sclk[0] !== 1'b0 || tx_ready[0] !== 1'b1) bad++;
        end
        check("t3 gap idle", 32'(bad), 32'd0);
        // count presented with byte 2 must be ignored
        tx_byte[0] = 8'h02; tx_count[0] = 3'd1; tx_dv[0] = 1'b1;
        tick(1);
        tx_dv[0] = 1'b0;
        tick(33);
        check("t3 b1 rxdv",  32'(rx_dv[0]),    32'd1);
        check("t3 b1 rxb",   32'(rx_byte[0]),  32'h02);
        check("t3 b1 cnt",   32'(rx_count[0]), 32'd1);
        check("t3 b1 cs",    32'(cs_n[0]),     32'd0);
        tx_byte[0] = 8'h03; tx_dv[0] = 1'b1;
        tick(1);
        tx_dv[0] = 1'b0;
        check("t3 b2 cs",    32'(cs_n[0]),     32'd0);
        tick(33);
        check("t3 b2 rxdv",  32'(rx_dv[0]),    32'd1);
        check("t3 b2 rxb",   32'(rx_byte[0]),  32'h03);
        check("t3 b2 cnt",   32'(rx_count[0]), 32'd2);
        check("t3 b2 cs",    32'(cs_n[0]),     32'd1);
        check("t3 b2 ready", 32'(tx_ready[0]), 32'd0);

        // CS gap then an immediate 1-byte frame with a dropped mid-byte DV
        bad = 0;
        repeat (3) begin
            tick(1);
            if (cs_n[0] !== 1'b1 || tx_ready[0] !== 1'b0) bad++;
        end
        check("t4 gap", 32'(bad), 32'd0);
        tick(1);
        check("t4 gap ready", 32'(tx_ready[0]), 32'd1);
        check("t4 gap cs",    32'(cs_n[0]),     32'd1);
        tx_byte[0] = 8'h5A; tx_count[0] = 3'd1; tx_dv[0] = 1'b1;
        tick(1);
        tx_dv[0] = 1'b0;
        check("t4 cs low after 5", 32'(cs_n[0]), 32'd0);
        tick(9);
        tx_byte[0] = 8'hFF; tx_count[0] = 3'd4; tx_dv[0] = 1'b1;
        tick(1);
        tx_dv[0] = 1'b0;
        check("t4 drop ready", 32'(tx_ready[0]), 32'd0);
        tick(22);
        check("t4 rxdv N+33", 32'(rx_dv[0]),    32'd0);
        tick(1);
        check("t4 rxdv",      32'(rx_dv[0]),    32'd1);
        check("t4 rxb",       32'(rx_byte[0]),  32'h5A);
        check("t4 cnt wrap",  32'(rx_count[0]), 32'd0);
        check("t4 cs",        32'(cs_n[0]),     32'd1);

        // count of zero behaves as one byte
        tick(4);
        tx_byte[0] = 8'h96; tx_count[0] = 3'd0; tx_dv[0] = 1'b1;
        tick(1);
        tx_dv[0] = 1'b0;
        tick(32);
        check("t6 cs N+33", 32'(cs_n[0]),    32'd0);
        tick(1);
        check("t6 rxdv",    32'(rx_dv[0]),   32'd1);
        check("t6 rxb",     32'(rx_byte[0]), 32'h96);
        check("t6 cs high", 32'(cs_n[0]),    32'd1);

        // asynchronous reset at edge 7 (modes 0 and 2)
        tick(4);
        tx_byte[0] = 8'hFF; tx_count[0] = 3'd1; tx_dv[0] = 1'b1;
        tx_byte[2] = 8'hFF; tx_count[2] = 3'd1; tx_dv[2] = 1'b1;
        tick(1);
        tx_dv = '0;
        tick(14);
        check("t5 edge7 sclk m0", 32'(sclk[0]), 32'd1);
        check("t5 edge7 sclk m2", 32'(sclk[2]), 32'd0);
        check("t5 edge7 mosi m0", 32'(mosi[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("t5 cs",    32'({cs_n[2], cs_n[0]}),         32'h3);
        check("t5 sclk",  32'({sclk[2], sclk[0]}),         32'h2);
        check("t5 mosi",  32'({mosi[2], mosi[0]}),         32'h0);
        check("t5 rxdv",  32'({rx_dv[2], rx_dv[0]}),       32'h0);
        check("t5 ready", 32'({tx_ready[2], tx_ready[0]}), 32'h0);
        tick(1);
        rst = 1'b0;
        #1;
        check("t5 ready at release", 32'(tx_ready[0]), 32'd0);
        tick(1);
        check("t5 ready after", 32'({tx_ready[2], tx_ready[0]}), 32'h3);
        check("t5 no rxdv",     32'(rx_dv),                      32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master.md
# spi_master

SPI master that serialises bytes from the FPGA clock domain onto SCLK/MOSI and captures MISO, controlling chip-select across multi-byte frames. It is the initiator-side counterpart of our SPI slave, and is used to drive external SPI peripherals and slave loopback benches. SCLK is generated by dividing i_Clk, so only one clock domain exists inside the block.

## Interface
- SPI_MODE, 0: CPOL = mode∈{2,3}, CPHA = mode∈{1,3}.
- CLKS_PER_HALF_BIT, 2: i_Clk cycles per SCLK half-period; must be ≥2.
- MAX_BYTES_PER_CS, 4: maximum bytes in one CS-low frame.
- CS_INACTIVE_CLKS, 4: minimum i_Clk cycles CS_n stays high between frames; must be ≥1.
- Let CW = $clog2(MAX_BYTES_PER_CS+1).

Ports:
- i_Clk  in  1  system clock; the only clock in the block.
- i_Rst  in  1  reset, asynchronous, active-high.
- i_TX_Count  in  CW  bytes in the frame; sampled only on the first byte of a frame.
- i_TX_Byte  in  8  byte to send; sampled when i_TX_DV && o_TX_Ready.
- i_TX_DV  in  1  request pulse; ignored while o_TX_Ready=0.
- o_TX_Ready  out  1  block can accept the next byte.
- o_RX_DV  out  1  one-cycle pulse when o_RX_Byte is valid.
- o_RX_Byte  out  8  received byte.
- o_RX_Count  out  CW  0-based index of o_RX_Byte within the current frame.
- o_SPI_Clk  out  1  SCLK.
- i_SPI_MISO  in  1  serial data in.
- o_SPI_MOSI  out  1  serial data out, MSb first.
- o_SPI_CS_n  out  1  chip select, active low.

## Operation
- FSM states:
  - IDLE: o_TX_Ready=1, CS_n=1.
    - On i_TX_DV: latch the count (a count of 0 is treated as 1), clear the remaining and RX counters, assert CS_n=0, start the byte engine, go to XFER.
  - XFER: byte in flight, o_TX_Ready=0.
    - At the end of a byte, if bytes remain: go to WAIT_NEXT.
    - At the end of a byte, if none remain: raise CS_n, go to CS_GAP.
  - WAIT_NEXT: CS_n stays 0, SCLK idle at CPOL, o_TX_Ready=1.
    - On i_TX_DV: start the next byte and return to XFER; i_TX_Count is ignored.
    - No timeout: the frame stays open indefinitely.
  - CS_GAP: counts CS_INACTIVE_CLKS cycles, then goes to IDLE.
- Byte engine:
  - 16 SCLK edges per byte; one edge every CLKS_PER_HALF_BIT cycles; SCLK toggles on each edge.
  - CPHA=0: MOSI bit7 is driven on the start cycle; sample MISO on leading (odd) edges; shift the next MOSI bit on trailing (even) edges 2,4,…,14.
  - CPHA=1: drive MOSI on leading edges; sample MISO on trailing edges.
  - RX shifts in at the LSb and moves toward the MSb.
- o_RX_Count increments after each o_RX_DV and wraps to 0 at a new frame.
- MOSI holds its last driven bit between bytes; it is 0 in IDLE.
- i_TX_DV while o_TX_Ready=0 is dropped, with no side effects.
- Reset, including mid-transfer, asynchronously forces:
  - state IDLE, CS_n=1, o_SPI_Clk=CPOL, o_SPI_MOSI=0;
  - o_TX_Ready=0, o_RX_DV=0, o_RX_Byte=0, o_RX_Count=0, all counters 0.
- o_TX_Ready rises on the first i_Clk edge after reset releases.

## Timing
- Byte accepted on cycle N (from IDLE):
  - CS_n=0 and MOSI=bit7 (CPHA=0) at N+1.
  - Edge k (1..16) occurs at N+1+k·CLKS_PER_HALF_BIT.
- o_RX_DV pulses one cycle after edge 16.
  - With CLKS_PER_HALF_BIT=2 that is N+34.
- In the same cycle as o_RX_DV:
  - the last byte of a frame raises CS_n;
  - otherwise o_TX_Ready rises.
- CS_n-low to first edge: CLKS_PER_HALF_BIT cycles. Last edge to CS_n high: 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Back-to-back frames: CS_n is high for exactly CS_INACTIVE_CLKS+1 cycles when the next i_TX_DV arrives on the first ready cycle.

## Structure
- Shared package spi_pkg holds:
  - the state enum (IDLE, XFER, WAIT_NEXT, CS_GAP);
  - a CPOL/CPHA decode function of SPI_MODE.
- The slave should import the same package for its mode decode.
- One sub-module, spi_master_byte, holds the half-bit counter, edge counter, TX/RX shift registers, SCLK generation, a start input and a done pulse.
- The top level holds the frame FSM, the byte/RX counters and the CS_n register.

## Test plan
- Mode 0, CLKS_PER_HALF_BIT=2, count 1, send 0xA5 with MISO looped to MOSI: o_RX_Byte=0xA5 and o_RX_DV at N+34, CS_n high at N+34, SCLK idles 0, exactly 8 rising edges.
- Modes 1/2/3, send 0x3C with the slave model returning 0xC3: received 0xC3, SCLK idle level equals CPOL, MOSI stable at every sampling edge.
- Count 3, bytes 0x01,0x02,0x03, with a 10-cycle i_TX_DV delay before byte 2: CS_n low throughout, o_RX_Count 0,1,2, SCLK idle during the gap.
- Two 1-byte frames with CS_INACTIVE_CLKS=4 and immediate re-request: CS_n high for 5 cycles; i_TX_DV during XFER is dropped and the frame contents are unchanged.
- Assert i_Rst at edge 7 of a byte: the same cycle shows CS_n=1, o_SPI_Clk=CPOL, MOSI=0, no o_RX_DV; o_TX_Ready=1 one cycle after release.
- i_TX_Count=0: treated as a 1-byte frame, CS_n raised after the byte.
